// File: rtl/alu_writeback.sv
// ALU result-commit stage: captures one result set per instruction, selects by
// opcode and writes it back through a handshaked port (two beats for multiply).
module alu_writeback #(
  parameter int DW = 16,
  parameter int AW = 6,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      select,
  input  logic [AW-1:0]   rdst1,
  input  logic [AW-1:0]   rdst2,
  input  logic [DW-1:0]   sum,
  input  logic [DW-1:0]   diff,
  input  logic [DW-1:0]   negate,
  input  logic [DW-1:0]   divi,
  input  logic [2*DW-1:0] multiplied,
  input  logic [DW-1:0]   or_gat,
  input  logic [DW-1:0]   xor_gat,
  input  logic [DW-1:0]   nand_gat,
  input  logic [DW-1:0]   nor_gat,
  input  logic [DW-1:0]   xnor_gat,
  input  logic [DW-1:0]   not_gat,
  input  logic [DW-1:0]   left_sft,
  input  logic [DW-1:0]   right_sft,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  input  logic            wr_ready,
  output logic            flag_z,
  output logic            flag_n,
  output logic            err_op,
  output logic [CW-1:0]   commit_cnt
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  localparam logic [5:0] OP_MUL = 6'd3;

  state_t        state;
  logic [DW-1:0] sel_lo;
  logic          sel_legal;
  logic          sel_zero;
  logic          sel_neg;
  logic [DW-1:0] hi_q;
  logic [AW-1:0] rdst2_q;
  logic          is_mul_q;
  logic          res_zero_q;
  logic          res_neg_q;

  always_comb begin
    sel_lo    = '0;
    sel_legal = 1'b1;
    case (select)
      6'd0:    sel_lo = sum;
      6'd1:    sel_lo = diff;
      6'd2:    sel_lo = negate;
      6'd3:    sel_lo = multiplied[DW-1:0];
      6'd4:    sel_lo = divi;
      6'd5:    sel_lo = or_gat;
      6'd6:    sel_lo = xor_gat;
      6'd7:    sel_lo = nand_gat;
      6'd8:    sel_lo = nor_gat;
      6'd9:    sel_lo = xnor_gat;
      6'd10:   sel_lo = not_gat;
      6'd11:   sel_lo = left_sft;
      6'd12:   sel_lo = right_sft;
      default: sel_legal = 1'b0;
    endcase
  end

  // Flags are resolved at capture over the full result (whole product for
  // mul) and only applied to flag_z/flag_n when the instruction commits.
  always_comb begin
    sel_zero = (sel_lo == '0);
    sel_neg  = sel_lo[DW-1];
    if (select == OP_MUL) begin
      sel_zero = (multiplied == '0);
      sel_neg  = multiplied[2*DW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      err_op     <= 1'b0;
      commit_cnt <= '0;
      hi_q       <= '0;
      rdst2_q    <= '0;
      is_mul_q   <= 1'b0;
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else begin
      err_op <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (sel_legal) begin
              state      <= WR_LO;
              in_ready   <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= rdst1;
              wr_data    <= sel_lo;
              hi_q       <= multiplied[2*DW-1:DW];
              rdst2_q    <= rdst2;
              is_mul_q   <= (select == OP_MUL);
              res_zero_q <= sel_zero;
              res_neg_q  <= sel_neg;
            end else begin
              err_op <= 1'b1;
            end
          end
        end
        WR_LO: begin
          if (wr_ready) begin
            if (is_mul_q) begin
              state   <= WR_HI;
              wr_addr <= rdst2_q;
              wr_data <= hi_q;
            end else begin
              state      <= IDLE;
              wr_en      <= 1'b0;
              in_ready   <= 1'b1;
              flag_z     <= res_zero_q;
              flag_n     <= res_neg_q;
              commit_cnt <= commit_cnt + CW'(1);
            end
          end
        end
        WR_HI: begin
          if (wr_ready) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            in_ready   <= 1'b1;
            flag_z     <= res_zero_q;
            flag_n     <= res_neg_q;
            commit_cnt <= commit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback (built with CW=4 to reach wrap).
module tb_alu_writeback;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      select;
  logic [AW-1:0]   rdst1, rdst2;
  logic [DW-1:0]   sum, diff, negate, divi;
  logic [2*DW-1:0] multiplied;
  logic [DW-1:0]   or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat;
  logic [DW-1:0]   left_sft, right_sft;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_ready;
  logic            flag_z, flag_n, err_op;
  logic [CW-1:0]   commit_cnt;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;

  alu_writeback #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .rdst1(rdst1), .rdst2(rdst2),
    .sum(sum), .diff(diff), .negate(negate), .divi(divi), .multiplied(multiplied),
    .or_gat(or_gat), .xor_gat(xor_gat), .nand_gat(nand_gat), .nor_gat(nor_gat),
    .xnor_gat(xnor_gat), .not_gat(not_gat), .left_sft(left_sft), .right_sft(right_sft),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .flag_z(flag_z), .flag_n(flag_n), .err_op(err_op), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distinct value on every result bus so a wrong select shows up as wrong data.
  task automatic load_buses();
    sum = 16'h1000; diff = 16'h1001; negate = 16'h1002; multiplied = 32'hABCD_1003;
    divi = 16'h1004; or_gat = 16'h1005; xor_gat = 16'h1006; nand_gat = 16'h1007;
    nor_gat = 16'h1008; xnor_gat = 16'h1009; not_gat = 16'h100A;
    left_sft = 16'h100B; right_sft = 16'h100C;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; wr_ready = 1'b0; select = '0; rdst1 = '0; rdst2 = '0;
    load_buses();
    tick(); tick();
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, flag_z, flag_n, err_op, commit_cnt} !==
        {1'b1, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL reset: rdy=%b en=%b addr=%0d data=%h z=%b n=%b err=%b cnt=%0d expected rdy=1 rest 0",
               in_ready, wr_en, wr_addr, wr_data, flag_z, flag_n, err_op, commit_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    tick();
  endtask

  task automatic test_add();
    select = 6'd0; rdst1 = 6'd5; sum = 16'h1234; wr_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; sum = 16'hDEAD;
    checks++;
    if ({wr_en, in_ready, wr_addr, wr_data} !== {1'b1, 1'b0, 6'd5, 16'h1234}) begin
      failures++;
      $display("FAIL add_beat: en=%b rdy=%b addr=%0d data=%h expected en=1 rdy=0 addr=5 data=1234",
               wr_en, in_ready, wr_addr, wr_data);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({wr_en, in_ready, commit_cnt, flag_z, flag_n} !== {1'b0, 1'b1, exp_cnt, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add_commit: en=%b rdy=%b cnt=%0d z=%b n=%b expected en=0 rdy=1 cnt=%0d z=0 n=0",
               wr_en, in_ready, commit_cnt, flag_z, flag_n, exp_cnt);
    end
  endtask

  task automatic test_mul_stall();
    select = 6'd3; rdst1 = 6'd2; rdst2 = 6'd3; multiplied = 32'hFFFE_0001;
    wr_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; multiplied = 32'h0000_0000; rdst1 = 6'd9; rdst2 = 6'd9;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({wr_en, in_ready, wr_addr, wr_data, commit_cnt} !== {1'b1, 1'b0, 6'd2, 16'h0001, exp_cnt}) begin
        failures++;
        $display("FAIL mul_lo_hold[%0d]: en=%b rdy=%b addr=%0d data=%h cnt=%0d expected en=1 rdy=0 addr=2 data=0001 cnt=%0d",
                 c, wr_en, in_ready, wr_addr, wr_data, commit_cnt, exp_cnt);
      end
      if (c == 3) wr_ready = 1'b1;
      tick();
    end
    checks++;
    if ({wr_en, in_ready, wr_addr, wr_data, commit_cnt} !== {1'b1, 1'b0, 6'd3, 16'hFFFE, exp_cnt}) begin
      failures++;
      $display("FAIL mul_hi: en=%b rdy=%b addr=%0d data=%h cnt=%0d expected en=1 rdy=0 addr=3 data=fffe cnt=%0d",
               wr_en, in_ready, wr_addr, wr_data, commit_cnt, exp_cnt);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({wr_en, in_ready, commit_cnt, flag_z, flag_n} !== {1'b0, 1'b1, exp_cnt, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mul_commit: en=%b rdy=%b cnt=%0d z=%b n=%b expected en=0 rdy=1 cnt=%0d z=0 n=1",
               wr_en, in_ready, commit_cnt, flag_z, flag_n, exp_cnt);
    end
  endtask

  task automatic test_zero();
    wr_ready = 1'b1;
    select = 6'd1; rdst1 = 6'd7; diff = 16'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({flag_z, flag_n, commit_cnt} !== {1'b1, 1'b0, exp_cnt}) begin
      failures++;
      $display("FAIL zero_sub: z=%b n=%b cnt=%0d expected z=1 n=0 cnt=%0d", flag_z, flag_n, commit_cnt, exp_cnt);
    end
    // Low word zero but product nonzero; same destination for both beats.
    select = 6'd3; rdst1 = 6'd9; rdst2 = 6'd9; multiplied = 32'h0001_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({wr_addr, wr_data} !== {6'd9, 16'h0000}) begin
      failures++;
      $display("FAIL mul_same_lo: addr=%0d data=%h expected addr=9 data=0000", wr_addr, wr_data);
    end
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd9, 16'h0001}) begin
      failures++;
      $display("FAIL mul_same_hi: en=%b addr=%0d data=%h expected en=1 addr=9 data=0001", wr_en, wr_addr, wr_data);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({flag_z, flag_n, commit_cnt} !== {1'b0, 1'b0, exp_cnt}) begin
      failures++;
      $display("FAIL mul_nonzero: z=%b n=%b cnt=%0d expected z=0 n=0 cnt=%0d", flag_z, flag_n, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_opcode_map();
    logic [DW-1:0] exp_data;
    wr_ready = 1'b1;
    for (int op = 0; op <= 12; op++) begin
      if (op == 3) continue;
      load_buses();
      select = 6'(op); rdst1 = 6'(op + 20); in_valid = 1'b1;
      exp_data = 16'h1000 + 16'(op);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'(op + 20), exp_data}) begin
        failures++;
        $display("FAIL opmap[%0d]: en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                 op, wr_en, wr_addr, wr_data, op + 20, exp_data);
      end
      tick();
      exp_cnt++;
    end
    checks++;
    if (commit_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL opmap_cnt: cnt=%0d expected %0d", commit_cnt, exp_cnt);
    end
    // Negative single-word result sets flag_n.
    xor_gat = 16'h8001; select = 6'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({flag_z, flag_n, commit_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
      failures++;
      $display("FAIL neg_flag: z=%b n=%b cnt=%0d expected z=0 n=1 cnt=%0d", flag_z, flag_n, commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    logic zf, nf;
    logic [5:0] bad [2] = '{6'd13, 6'd63};
    zf = flag_z; nf = flag_n;
    wr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      select = bad[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({err_op, wr_en, in_ready} !== {1'b1, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL illegal_pulse[%0d]: err=%b en=%b rdy=%b expected err=1 en=0 rdy=1", bad[i], err_op, wr_en, in_ready);
      end
      tick();
      checks++;
      if ({err_op, wr_en, in_ready, commit_cnt, flag_z, flag_n} !== {1'b0, 1'b0, 1'b1, exp_cnt, zf, nf}) begin
        failures++;
        $display("FAIL illegal_after[%0d]: err=%b en=%b rdy=%b cnt=%0d z=%b n=%b expected err=0 en=0 rdy=1 cnt=%0d z=%b n=%b",
                 bad[i], err_op, wr_en, in_ready, commit_cnt, flag_z, flag_n, exp_cnt, zf, nf);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    select = 6'd3; rdst1 = 6'd4; rdst2 = 6'd6; multiplied = 32'h8000_0000; wr_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 6'd6, 16'h8000}) begin
      failures++;
      $display("FAIL rst_mul_hi: en=%b addr=%0d data=%h expected en=1 addr=6 data=8000", wr_en, wr_addr, wr_data);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    checks++;
    if ({wr_en, in_ready, commit_cnt, flag_z, flag_n} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_mul: en=%b rdy=%b cnt=%0d z=%b n=%b expected en=0 rdy=1 cnt=0 z=0 n=0",
               wr_en, in_ready, commit_cnt, flag_z, flag_n);
    end
    select = 6'd0; rdst1 = 6'd1; sum = 16'h0042; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if ({commit_cnt, wr_en, in_ready} !== {exp_cnt, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL post_rst_add: cnt=%0d en=%b rdy=%b expected cnt=%0d en=0 rdy=1", commit_cnt, wr_en, in_ready, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    select = 6'd0; rdst1 = 6'd10; sum = 16'h0005; wr_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({wr_en, in_ready} !== {1'b1, 1'b0}) begin
        failures++;
        $display("FAIL b2b_write[%0d]: en=%b rdy=%b expected en=1 rdy=0", k, wr_en, in_ready);
      end
      tick();
      exp_cnt++;
      checks++;
      if ({commit_cnt, in_ready} !== {exp_cnt, 1'b1}) begin
        failures++;
        $display("FAIL b2b_cnt[%0d]: cnt=%0d rdy=%b expected cnt=%0d rdy=1", k, commit_cnt, in_ready, exp_cnt);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_stall();
    test_zero();
    test_opcode_map();
    test_illegal();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
